// File: rtl/uart_rx_16x_if.sv
// uart_rx_16x_if: byte hand-off bundle between the UART receiver and its
// consumer (command/PUF logic). The master side is the receiver.
interface uart_rx_16x_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 rx_frame_err;
   logic                 rx_overrun;
   logic                 rx_parity_err;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      output rx_frame_err,
      output rx_overrun,
      output rx_parity_err
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      input  rx_frame_err,
      input  rx_overrun,
      input  rx_parity_err
   );
endinterface

// File: rtl/uart_rx_16x.sv
// uart_rx_16x: oversampling UART receiver (8N1 default) on the system clock.
// The 16x divider waveform is only used as a sample-rate reference: its
// synchronised rising edge produces a one-clk tick that advances the FSM.
// Each bit is decided by a 2-of-3 vote at the middle samples.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit after data.
module uart_rx_16x #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sample_clk_in,
   input  logic          rxd,
   uart_rx_16x_if.master rx_if
);

   localparam int unsigned M  = OVERSAMPLE / 2;
   localparam int unsigned CW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] S_LO   = CW'(M - 1);
   localparam logic [CW-1:0] S_MID  = CW'(M);
   localparam logic [CW-1:0] S_HI   = CW'(M + 1);
   localparam logic [CW-1:0] S_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t               state;
   logic [CW-1:0]        scnt;
   logic [BW-1:0]        bidx;
   logic [DATA_BITS-1:0] shreg;
   logic                 armed;
   logic                 samp_lo;
   logic                 samp_mid;

   logic                 sclk_m;
   logic                 sclk_s;
   logic                 sclk_d;
   logic                 rxd_m;
   logic                 rxd_s;

   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_valid_q;
   logic                 ferr_q;
   logic                 ovr_q;

   logic                 tick;
   logic                 vote;
   logic                 consume;

`ifdef UART_RX_PARITY_EN
   logic                 par_bit;
   logic                 perr_q;
`endif

   // Two-flop synchronisers for the divider waveform and the serial line,
   // plus a delayed copy of the waveform for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_m <= 1'b1;
         sclk_s <= 1'b1;
         sclk_d <= 1'b1;
         rxd_m  <= 1'b1;
         rxd_s  <= 1'b1;
      end else begin
         sclk_m <= sample_clk_in;
         sclk_s <= sclk_m;
         sclk_d <= sclk_s;
         rxd_m  <= rxd;
         rxd_s  <= rxd_m;
      end
   end

   assign tick    = sclk_s & ~sclk_d;
   // Third vote sample is the live synchronised line at scnt = M+1.
   assign vote    = (samp_lo & samp_mid) | (samp_lo & rxd_s) | (samp_mid & rxd_s);
   assign consume = rx_valid_q & rx_if.rx_ready;

   // Receive FSM, bit sampling, and the one-deep output buffer with its flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         scnt       <= '0;
         bidx       <= '0;
         shreg      <= '0;
         armed      <= 1'b0;
         samp_lo    <= 1'b0;
         samp_mid   <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit    <= 1'b0;
         perr_q     <= 1'b0;
`endif
      end else begin
         ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q <= 1'b0;
`endif
         // A consume may be overridden below by a same-cycle completion,
         // which is how "simultaneous set wins" falls out for valid/overrun.
         if (consume) begin
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
         end

         if (tick) begin
            if (scnt == S_LO) begin
               samp_lo <= rxd_s;
            end
            if (scnt == S_MID) begin
               samp_mid <= rxd_s;
            end

            case (state)
               IDLE: begin
                  if (rxd_s) begin
                     armed <= 1'b1;
                  end else if (armed) begin
                     state <= START;
                     scnt  <= CW'(1);
                     armed <= 1'b0;
                  end
               end

               START: begin
                  if (scnt == S_HI && vote) begin
                     state <= IDLE;
                     scnt  <= '0;
                  end else if (scnt == S_LAST) begin
                     state <= DATA;
                     scnt  <= '0;
                     bidx  <= '0;
                  end else begin
                     scnt <= scnt + CW'(1);
                  end
               end

               DATA: begin
                  if (scnt == S_HI) begin
                     shreg <= {vote, shreg[DATA_BITS-1:1]};
                  end
                  if (scnt == S_LAST) begin
                     scnt <= '0;
                     if (bidx == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end else begin
                        bidx <= bidx + BW'(1);
                     end
                  end else begin
                     scnt <= scnt + CW'(1);
                  end
               end

`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  if (scnt == S_HI) begin
                     par_bit <= vote;
                  end
                  if (scnt == S_LAST) begin
                     state <= STOP;
                     scnt  <= '0;
                  end else begin
                     scnt <= scnt + CW'(1);
                  end
               end
`endif

               STOP: begin
                  // Decide mid stop bit and return to IDLE at once so the
                  // next start edge can be caught; armed is already 0, so a
                  // held-low break line cannot retrigger.
                  if (scnt == S_HI) begin
                     state <= IDLE;
                     scnt  <= '0;
                     if (vote) begin
                        if (!rx_valid_q || consume) begin
                           rx_data_q  <= shreg;
                           rx_valid_q <= 1'b1;
                        end else begin
                           ovr_q <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        perr_q <= ^{shreg, par_bit};
`endif
                     end else begin
                        ferr_q <= 1'b1;
                     end
                  end else begin
                     scnt <= scnt + CW'(1);
                  end
               end

               default: begin
                  state <= IDLE;
                  scnt  <= '0;
               end
            endcase
         end
      end
   end

   assign rx_if.rx_data      = rx_data_q;
   assign rx_if.rx_valid     = rx_valid_q;
   assign rx_if.rx_frame_err = ferr_q;
   assign rx_if.rx_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign rx_if.rx_parity_err = perr_q;
`else
   assign rx_if.rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_16x.sv
// Testbench for uart_rx_16x: directed corner sequences, a table of frames
// with hand-computed results, and randomized frames against a frame-level
// reference model of the output buffer and error flags.
module tb_uart_rx_16x;

   localparam int unsigned OS = 16;
   localparam int unsigned DB = 8;

   logic clk           = 1'b0;
   logic rst_n         = 1'b0;
   logic sample_clk_in = 1'b0;
   logic rxd           = 1'b1;

   uart_rx_16x_if #(.DATA_BITS(DB)) rx_if ();

   uart_rx_16x #(
      .OVERSAMPLE(OS),
      .DATA_BITS (DB)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_clk_in(sample_clk_in),
      .rxd          (rxd),
      .rx_if        (rx_if.master)
   );

   always #5 clk = ~clk;
   always #30 sample_clk_in = ~sample_clk_in;

   int tests = 0;
   int fails = 0;
   int ferr_cnt = 0;
   int perr_cnt = 0;

   // Frame-level model of the receiver's visible state.
   bit         mv;
   logic [7:0] md;
   bit         mov;
   int         mferr;
   int         mperr;

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      bit         consume;
      bit         exp_valid;
      logic [7:0] exp_data;
      bit         exp_ov;
      int         exp_ferr_inc;
   } vec_t;

   vec_t vecs[7];

   // Count one-clk error pulses away from the active edge.
   always @(negedge clk) begin
      if (rx_if.rx_frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
      if (rx_if.rx_parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic ticks(input int unsigned n);
      repeat (n) @(negedge sample_clk_in);
   endtask

   task automatic send_bit(input bit v);
      rxd = v;
      ticks(OS);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip,
                             input int unsigned low_hold);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ par_flip);
`endif
      send_bit(stop_ok);
      if (!stop_ok) begin
         ticks(low_hold);
         rxd = 1'b1;
      end
      if (stop_ok) begin
         if (mv) mov = 1'b1;
         else begin
            mv = 1'b1;
            md = d;
         end
`ifdef UART_RX_PARITY_EN
         if (par_flip) mperr++;
`endif
      end else begin
         mferr++;
      end
   endtask

   task automatic idle(input int unsigned n);
      rxd = 1'b1;
      ticks(n);
   endtask

   task automatic consume_pulse();
      @(negedge clk);
      rx_if.rx_ready = 1'b1;
      @(negedge clk);
      rx_if.rx_ready = 1'b0;
      if (mv) begin
         mv  = 1'b0;
         mov = 1'b0;
      end
      ticks(2);
   endtask

   task automatic check_model(input string name);
      check({name, "_valid"}, rx_if.rx_valid, mv);
      check({name, "_data"}, rx_if.rx_data, md);
      check({name, "_ovr"}, rx_if.rx_overrun, mov);
      check({name, "_ferr"}, ferr_cnt, mferr);
      check({name, "_perr"}, perr_cnt, mperr);
   endtask

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int base;
      logic [7:0] rd;
      bit rs, rc, rp;

      vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 0};
      vecs[1] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 0};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 0};
      vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1};
      vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1};
      vecs[5] = '{8'h01, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 2};
      vecs[6] = '{8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 2};

      mv = 1'b0; md = 8'h00; mov = 1'b0; mferr = 0; mperr = 0;
      rx_if.rx_ready = 1'b0;
      rxd = 1'b1;

      // Reset state
      repeat (4) @(negedge clk);
      check("rst_valid", rx_if.rx_valid, 1'b0);
      check("rst_data", rx_if.rx_data, 8'h00);
      check("rst_ovr", rx_if.rx_overrun, 1'b0);
      check("rst_ferr", rx_if.rx_frame_err, 1'b0);
      check("rst_perr", rx_if.rx_parity_err, 1'b0);
      rst_n = 1'b1;
      idle(32);

      // 0xA5 held while rx_ready=0, then one consume
      send_frame(8'hA5, 1'b1, 1'b0, 0);
      check("a5_valid", rx_if.rx_valid, 1'b1);
      check("a5_data", rx_if.rx_data, 8'hA5);
      idle(OS);
      check("a5_held", rx_if.rx_valid, 1'b1);
      consume_pulse();
      check("a5_consumed", rx_if.rx_valid, 1'b0);

      // False start: 5 low ticks
      base = ferr_cnt;
      rxd = 1'b0;
      ticks(5);
      idle(32);
      check("fstart_valid", rx_if.rx_valid, 1'b0);
      check("fstart_ferr", ferr_cnt, base);
      check("fstart_ovr", rx_if.rx_overrun, 1'b0);

      // Bad stop on 0x3C, break for 3 bit times, then 0x55
      base = ferr_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, 3 * OS);
      check("brk_valid", rx_if.rx_valid, 1'b0);
      check("brk_ferr", ferr_cnt, base + 1);
      idle(OS);
      send_frame(8'h55, 1'b1, 1'b0, 0);
      idle(4);
      check("brk55_data", rx_if.rx_data, 8'h55);
      check("brk55_valid", rx_if.rx_valid, 1'b1);
      check("brk55_ferr", ferr_cnt, base + 1);

      // Back to back 0x12, 0x34 with no consume: overrun
      consume_pulse();
      send_frame(8'h12, 1'b1, 1'b0, 0);
      send_frame(8'h34, 1'b1, 1'b0, 0);
      check("ovr_data", rx_if.rx_data, 8'h12);
      check("ovr_flag", rx_if.rx_overrun, 1'b1);
      check("ovr_valid", rx_if.rx_valid, 1'b1);
      consume_pulse();
      check("ovr_clr", rx_if.rx_overrun, 1'b0);
      check("ovr_valid_clr", rx_if.rx_valid, 1'b0);

      // Reset during bit 4 of 0xFF, then 0x81
      base = ferr_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      ticks(5);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      mv = 1'b0; md = 8'h00; mov = 1'b0;
      ticks(1);
      idle(5 * OS);
      check("rstmid_valid", rx_if.rx_valid, 1'b0);
      send_frame(8'h81, 1'b1, 1'b0, 0);
      idle(4);
      check("rstmid_data", rx_if.rx_data, 8'h81);
      check("rstmid_valid2", rx_if.rx_valid, 1'b1);
      check("rstmid_ferr", ferr_cnt, base);
      check("rstmid_ovr", rx_if.rx_overrun, 1'b0);

`ifdef UART_RX_PARITY_EN
      // Even parity: good then flipped parity bit on 0x07
      consume_pulse();
      base = perr_cnt;
      send_frame(8'h07, 1'b1, 1'b0, 0);
      check("par_ok_data", rx_if.rx_data, 8'h07);
      check("par_ok_err", perr_cnt, base);
      consume_pulse();
      send_frame(8'h07, 1'b1, 1'b1, 0);
      check("par_bad_data", rx_if.rx_data, 8'h07);
      check("par_bad_valid", rx_if.rx_valid, 1'b1);
      check("par_bad_err", perr_cnt, base + 1);
`endif

      // Table of frames with fixed expectations
      consume_pulse();
      base = ferr_cnt;
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].consume) consume_pulse();
         send_frame(vecs[i].data, vecs[i].stop_ok, 1'b0, 0);
         idle(8);
         check($sformatf("vec%0d_valid", i), rx_if.rx_valid, vecs[i].exp_valid);
         check($sformatf("vec%0d_data", i), rx_if.rx_data, vecs[i].exp_data);
         check($sformatf("vec%0d_ovr", i), rx_if.rx_overrun, vecs[i].exp_ov);
         check($sformatf("vec%0d_ferr", i), ferr_cnt - base, vecs[i].exp_ferr_inc);
      end

      // Randomized frames against the model
      for (int i = 0; i < 16; i++) begin
         rd = 8'($urandom);
         rs = ($urandom_range(0, 7) != 0);
         rc = ($urandom_range(0, 1) == 1);
         rp = ($urandom_range(0, 3) == 0);
`ifndef UART_RX_PARITY_EN
         rp = 1'b0;
`endif
         if (rc) consume_pulse();
         send_frame(rd, rs, rp, $urandom_range(0, 20));
         idle($urandom_range(1, 20));
         check_model($sformatf("rnd%0d", i));
      end

      consume_pulse();
      check("final_valid", rx_if.rx_valid, 1'b0);
      check("final_perr", perr_cnt, mperr);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx_16x.md
Name: uart_rx_16x

Overview:
- Serial UART receiver, 8N1 by default, downstream of the 16x receive divider.
- Consumes the divider's clk_out waveform as a sample-rate reference, not as a clock.
- Runs entirely on the system clk.
- Recovers bytes from the rxd line by 16x oversampling with a 3-sample majority vote.
- Presents each byte on a valid/ready interface to the command/PUF logic.

Parameters:
- OVERSAMPLE, 16: sample ticks per bit; must be even and at least 8.
- DATA_BITS, 8: data bits per frame, sent LSB first.

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst_n, input, 1: asynchronous active-low reset.
- sample_clk_in, input, 1: divider output waveform, about 16x baud; asynchronous to the internal logic.
- rxd, input, 1: serial line, idle high, asynchronous.
- rx_data, output, DATA_BITS: received byte.
- rx_valid, output, 1: rx_data holds an unconsumed byte.
- rx_ready, input, 1: consumer accepts the byte.
- rx_frame_err, output, 1: one-clk pulse when the stop bit samples low.
- rx_overrun, output, 1: sticky flag; a byte was dropped because the buffer was full.
- rx_parity_err, output, 1: one-clk pulse on parity mismatch; tied 0 without UART_RX_PARITY_EN.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_parity_err=0, FSM=IDLE, armed=0, counters=0, synchronisers=1.
- Synchronisation:
  - sample_clk_in and rxd each pass through 2 flip-flops.
  - tick is a one-clk pulse on the rising edge of the synchronised sample_clk_in.
  - All FSM and counter activity advances only on tick.
- Sample counter scnt runs 0..OVERSAMPLE-1 within each bit.
- Majority vote: samples at scnt = M-1, M, M+1 with M = OVERSAMPLE/2 (7, 8, 9 for 16); the vote is 2-of-3.
- IDLE:
  - armed is set on any tick with rxd_s=1.
  - On a tick with armed=1 and rxd_s=0: go to START, scnt=1.
  - armed is cleared on leaving IDLE.
- START:
  - Vote resolved at scnt=M+1.
  - Vote=1 means a false start: return to IDLE, no outputs change.
  - Vote=0 continues; at scnt=OVERSAMPLE-1, go to DATA with bit index 0 and scnt=0.
- DATA:
  - Each bit's vote is shifted in LSB first at scnt=M+1.
  - At scnt=OVERSAMPLE-1 of the last bit (index DATA_BITS-1), go to PARITY if the macro is defined, else to STOP.
- STOP:
  - Vote resolved at scnt=M+1, then the FSM returns to IDLE immediately, with no wait for end of stop bit, to allow resync.
  - Vote=1: the frame completes.
  - Vote=0: rx_frame_err pulses for 1 clk on the next edge and the byte is discarded. armed=0 means a held-low (break) line cannot retrigger until rxd returns high.
- Completion, on the clk edge after the deciding tick:
  - Buffer empty (rx_valid=0) or being consumed this cycle (rx_valid & rx_ready): rx_data is loaded and rx_valid goes to 1.
  - Otherwise the new byte is dropped, rx_overrun is set to 1 and rx_data is unchanged.
- Handshake:
  - rx_valid & rx_ready on an edge consumes the byte: rx_valid goes to 0 unless a completion loads in the same cycle, in which case it stays 1 with the new data.
  - rx_data is stable while rx_valid=1.
  - rx_overrun clears on the next consume; a simultaneous set wins.
- Reset asserted mid-frame aborts the frame immediately to reset values; after release a new start is accepted only after rxd_s=1 is seen.
- Latency: rx_valid rises 1 clk after the tick at scnt=M+1 of the stop bit, about 9.5 bit times after the start edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA, lasting OVERSAMPLE ticks with the vote at scnt=M+1.
  - Expected parity is even: XOR of the data bits plus the parity bit must be 0.
  - On mismatch, rx_parity_err pulses 1 clk at completion, and the byte is still delivered if the stop bit is good.
- Undefined: no PARITY state; rx_parity_err is constant 0.

Test Plan:
- Byte 0xA5, 16 ticks/bit, 8N1, rx_ready=0 → rx_data=0xA5, rx_valid=1 held; then rx_ready=1 for 1 clk → rx_valid=0.
- rxd low for 5 ticks then high → returns to IDLE; rx_valid, rx_frame_err and rx_overrun all stay 0.
- Frame 0x3C with stop bit 0, then rxd held low for 3 bit times, then high and 0x55 sent → one rx_frame_err pulse, no delivery of 0x3C, no spurious start while low, rx_data=0x55.
- Bytes 0x12 then 0x34 back to back with rx_ready=0 → rx_data=0x12, rx_overrun=1; after one consume, rx_overrun=0 and rx_valid=0.
- Reset pulsed at bit 4 of 0xFF, then 0x81 sent → rx_data=0x81 with no error flags.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 → rx_data=0x07, no error; with parity bit 0 → rx_parity_err pulses and rx_data=0x07 is delivered.
